// File: rtl/cic_iq_pkg.sv
// Shared constants and state type for the CIC I/Q sequencer slice.
package cic_iq_pkg;

  localparam int DW  = 32;
  localparam int NRX = 3;
  localparam int NCH = 2 * NRX;
  localparam int CHW = 3;

  typedef enum logic [1:0] {
    EXPECT_SOP = 2'd0,
    COLLECT    = 2'd1,
    FULL       = 2'd2
  } asm_state_e;

endpackage

// File: rtl/cic_iq_gather.sv
// Input side of the sequencer: one holding register and pending flag per
// receiver, merged into a six-word parallel set for the decimator.
module cic_iq_gather
  import cic_iq_pkg::*;
#(
  parameter int GDW  = cic_iq_pkg::DW,
  parameter int GNRX = cic_iq_pkg::NRX
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [GNRX-1:0]       rx_en,
  input  logic [GNRX-1:0]       rx_valid,
  input  logic [GNRX*2*GDW-1:0] rx_data,
  input  logic                  cic_in_ready,
  input  logic                  clr_status,
  output logic                  cic_in_valid,
  output logic [GNRX*2*GDW-1:0] cic_in_data,
  output logic [GNRX-1:0]       ovf_sticky
);

  logic [GNRX-1:0]       captured;
  logic [GNRX-1:0]       pending;
  logic [GNRX*2*GDW-1:0] hold;
  logic [GNRX-1:0]       overrun;
  logic                  transfer;

  // A disabled receiver never holds up the set, so it always looks pending.
  assign pending      = captured | ~rx_en;
  assign cic_in_valid = &pending;
  assign transfer     = cic_in_valid & cic_in_ready;

  // Receiver r's {Q,I} pair already sits at words 2r and 2r+1, so the
  // holding registers map straight onto the decimator's parallel input.
  assign cic_in_data  = hold;

  // A strobe collides only if its slot is still full and is not being
  // emptied by a transfer in the same cycle.
  assign overrun      = rx_en & rx_valid & captured & ~{GNRX{transfer}};

  // Capture strobes into free slots, release slots on transfer, and force
  // disabled receivers to an empty, zero-valued slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      captured <= '0;
      hold     <= '0;
    end else begin
      for (int r = 0; r < GNRX; r++) begin
        if (!rx_en[r]) begin
          captured[r]               <= 1'b0;
          hold[r*2*GDW +: 2*GDW]    <= '0;
        end else if (rx_valid[r]) begin
          if (!captured[r] || transfer) begin
            hold[r*2*GDW +: 2*GDW]  <= rx_data[r*2*GDW +: 2*GDW];
            captured[r]             <= 1'b1;
          end
        end else if (transfer) begin
          captured[r]               <= 1'b0;
        end
      end
    end
  end

  // Sticky overrun flags; a new overrun beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_sticky <= '0;
    end else begin
      for (int r = 0; r < GNRX; r++) begin
        if (overrun[r]) begin
          ovf_sticky[r] <= 1'b1;
        end else if (clr_status) begin
          ovf_sticky[r] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/cic_iq_seq.sv
// Sequencer and frame controller around the six-channel CIC decimator:
// gathers receiver samples into parallel sets and rebuilds decimated
// channel-serial output into whole I/Q frames.
module cic_iq_seq
  import cic_iq_pkg::*;
#(
  parameter int DW  = cic_iq_pkg::DW,
  parameter int NRX = cic_iq_pkg::NRX,
  parameter int CHW = cic_iq_pkg::CHW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRX-1:0]        rx_en,
  input  logic [NRX-1:0]        rx_valid,
  input  logic [NRX*2*DW-1:0]   rx_data,
  output logic                  cic_in_valid,
  input  logic                  cic_in_ready,
  output logic [2*NRX*DW-1:0]   cic_in_data,
  output logic [1:0]            cic_in_error,
  input  logic [DW-1:0]         cic_out_data,
  input  logic [CHW-1:0]        cic_out_channel,
  input  logic                  cic_out_sop,
  input  logic                  cic_out_eop,
  input  logic                  cic_out_valid,
  input  logic [1:0]            cic_out_error,
  output logic                  cic_out_ready,
  output logic                  frm_valid,
  input  logic                  frm_ready,
  output logic [2*NRX*DW-1:0]   frm_data,
  output logic                  frm_err,
  output logic [15:0]           frm_cnt,
  output logic [NRX-1:0]        ovf_sticky,
  output logic                  seq_err_sticky,
  input  logic                  clr_status
);

  localparam int SEQ_NCH = 2 * NRX;

  asm_state_e     state;
  logic [CHW-1:0] expected;
  logic           beat_fire;
  logic           beat_err;
  logic           is_start;
  logic           last_ch;
  logic           in_order;
  logic           seq_set;

  cic_iq_gather #(
    .GDW  (DW),
    .GNRX (NRX)
  ) u_gather (
    .clk          (clk),
    .reset        (reset),
    .rx_en        (rx_en),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .cic_in_ready (cic_in_ready),
    .clr_status   (clr_status),
    .cic_in_valid (cic_in_valid),
    .cic_in_data  (cic_in_data),
    .ovf_sticky   (ovf_sticky)
  );

  assign cic_in_error  = 2'b00;

  // The decimator is stalled while a finished frame waits for downstream,
  // and also while reset is held.
  assign cic_out_ready = !reset && (state != FULL);

  assign beat_fire = cic_out_valid & cic_out_ready;
  assign beat_err  = |cic_out_error;
  assign is_start  = (cic_out_channel == '0) & cic_out_sop;
  assign last_ch   = (cic_out_channel == CHW'(SEQ_NCH - 1));
  assign in_order  = (cic_out_channel == expected) & !cic_out_sop &
                     (cic_out_eop == last_ch);
  assign seq_set   = beat_fire &
                     (((state == EXPECT_SOP) & !is_start) |
                      ((state == COLLECT) & !in_order));

  // Frame assembly: wait for channel 0 with sop, collect channels in order,
  // then hold the finished frame until the downstream stage takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EXPECT_SOP;
      expected  <= '0;
      frm_valid <= 1'b0;
      frm_data  <= '0;
      frm_err   <= 1'b0;
      frm_cnt   <= '0;
    end else begin
      case (state)
        EXPECT_SOP: begin
          if (beat_fire && is_start) begin
            frm_data[DW-1:0] <= cic_out_data;
            frm_err          <= beat_err;
            expected         <= CHW'(1);
            state            <= COLLECT;
          end
        end
        COLLECT: begin
          if (beat_fire) begin
            if (in_order) begin
              frm_data[cic_out_channel*DW +: DW] <= cic_out_data;
              frm_err <= frm_err | beat_err;
              if (last_ch) begin
                state     <= FULL;
                frm_valid <= 1'b1;
              end else begin
                expected  <= expected + CHW'(1);
              end
            end else if (is_start) begin
              frm_data[DW-1:0] <= cic_out_data;
              frm_err          <= beat_err;
              expected         <= CHW'(1);
            end else begin
              state <= EXPECT_SOP;
            end
          end
        end
        FULL: begin
          if (frm_ready) begin
            frm_valid <= 1'b0;
            frm_cnt   <= frm_cnt + 16'd1;
            state     <= EXPECT_SOP;
          end
        end
        default: state <= EXPECT_SOP;
      endcase
    end
  end

  // Sticky sequence-error flag; a new violation beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_err_sticky <= 1'b0;
    end else if (seq_set) begin
      seq_err_sticky <= 1'b1;
    end else if (clr_status) begin
      seq_err_sticky <= 1'b0;
    end
  end

endmodule
